// File: rtl/key_pkg.sv
// Shared types and helpers for the key debouncer.
// Holds the FSM state encoding and the ms-to-cycles conversion.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports: clk, rst (sync, active-high, clears to 0), d (async in), q (synced out).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Debouncer for an active-low push button with press/release/long-press pulses.
// Ports: clk, rst (sync, active-high), key_n (raw, low = pressed),
//        key_level (debounced, 1 = pressed), key_press / key_release / key_long
//        (registered one-cycle pulses).
module key_debounce
    import key_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int N  = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
    localparam int L  = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);
    localparam int CW = $clog2(L + 1);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_N   = CW'(N);
    localparam logic [CW-1:0] CNT_L   = CW'(L);
    localparam logic [CW-1:0] CNT_LM1 = CW'(L - 1);

    key_state_e      state;
    logic [CW-1:0]   deb_cnt;
    logic [CW-1:0]   hold_cnt;
    logic            s;
    logic            pressed_st;
    logic            rel_now;
    logic            press_now;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (~key_n),
        .q   (s)
    );

    assign pressed_st = (state == HELD) || (state == RELEASE_WAIT);
    assign key_level  = pressed_st;
    assign press_now  = (state == PRESS_WAIT) && s && (deb_cnt == CNT_N);
    assign rel_now    = (state == RELEASE_WAIT) && !s && (deb_cnt == CNT_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= press_now;
            key_release <= rel_now;
            unique case (state)
                IDLE: begin
                    if (s) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == CNT_N) begin
                        state   <= HELD;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state   <= HELD;
                        deb_cnt <= '0;
                    end else if (deb_cnt == CNT_N) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

    // Hold time saturates at L, so the long pulse can fire only once per
    // press even if a release bounce drops back into HELD.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            key_long <= 1'b0;
        end else begin
            key_long <= 1'b0;
            if (press_now) begin
                hold_cnt <= '0;
            end else if (pressed_st && hold_cnt != CNT_L) begin
                hold_cnt <= hold_cnt + CNT_ONE;
                // a release landing on the same edge wins over the long pulse
                if (hold_cnt == CNT_LM1 && !rel_now) begin
                    key_long <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with N=4, L=20.
// Stimulus queues expected pulses; a monitor matches them to DUT pulses.
module tb_key_debounce;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_n = 1'b1;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_long;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    key_debounce #(
        .CLK_FREQ_HZ (1000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)",
                     name, got, want, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard in kind
    // and cycle; an expected pulse whose cycle passes unseen is a miss.
    always @(negedge clk) begin
        int   np;
        int   kind;
        exp_t e;
        np = int'(key_press) + int'(key_release) + int'(key_long);
        kind = key_press ? K_PRESS : (key_release ? K_REL : K_LONG);
        if (np > 1) begin
            checks++;
            errors++;
            $display("FAIL exclusive: %0d pulses at cyc %0d", np, cyc);
        end else if (np == 1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected: kind %0d at cyc %0d, want none",
                         kind, cyc);
            end else begin
                e = sb.pop_front();
                if (e.kind != kind || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL pulse: got kind %0d cyc %0d, want kind %0d cyc %0d",
                             kind, cyc, e.kind, e.cyc);
                end
            end
        end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            e = sb.pop_front();
            $display("FAIL missed: got none, want kind %0d at cyc %0d",
                     e.kind, e.cyc);
        end
    end

    initial begin
        int b;
        int r;

        // reset
        rst   = 1'b1;
        key_n = 1'b1;
        step(3);
        chk("rst_level", int'(key_level), 0);
        chk("rst_press", int'(key_press), 0);
        chk("rst_release", int'(key_release), 0);
        chk("rst_long", int'(key_long), 0);
        rst = 1'b0;
        step(3);

        // clean press, long hold, release
        key_n = 1'b0;
        push(K_PRESS, cyc + 7);
        push(K_LONG, cyc + 27);
        step(6);
        chk("level_before_press", int'(key_level), 0);
        step(1);
        chk("level_at_press", int'(key_level), 1);
        step(30);
        chk("level_long_hold", int'(key_level), 1);
        key_n = 1'b1;
        push(K_REL, cyc + 7);
        step(6);
        chk("level_before_rel", int'(key_level), 1);
        step(1);
        chk("level_after_rel", int'(key_level), 0);
        step(10);

        // bounce on press: low 3, high 1, then low steady
        b = cyc;
        key_n = 1'b0;
        step(3);
        key_n = 1'b1;
        step(1);
        key_n = 1'b0;
        push(K_PRESS, cyc + 7);
        step(6);
        chk("bounce_level_pre", int'(key_level), 0);
        step(1);
        chk("bounce_level", int'(key_level), 1);
        chk("bounce_latency", cyc - b, 11);
        key_n = 1'b1;
        push(K_REL, cyc + 7);
        step(12);

        // release glitch during HELD must not disturb long timing
        key_n = 1'b0;
        push(K_PRESS, cyc + 7);
        push(K_LONG, cyc + 27);
        step(12);
        key_n = 1'b1;
        step(2);
        key_n = 1'b0;
        step(6);
        chk("glitch_level", int'(key_level), 1);
        step(22);
        key_n = 1'b1;
        push(K_REL, cyc + 7);
        step(12);

        // reset mid-hold with key still held
        key_n = 1'b0;
        push(K_PRESS, cyc + 7);
        step(12);
        rst = 1'b1;
        r = cyc;
        step(1);
        chk("midrst_level", int'(key_level), 0);
        chk("midrst_press", int'(key_press), 0);
        chk("midrst_release", int'(key_release), 0);
        chk("midrst_long", int'(key_long), 0);
        rst = 1'b0;
        push(K_PRESS, cyc + 7);
        step(7);
        chk("rerst_level", int'(key_level), 1);
        chk("rerst_latency", cyc - r, 8);
        key_n = 1'b1;
        push(K_REL, cyc + 7);
        step(12);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
